// File: rtl/bus_router.sv
// bus_router: single-outstanding CPU bus decoder and router.
// The CPU request is broadcast to four targets (ROM, RAM, UART, CLINT).
// A target's valid is raised only on the acceptance cycle. The latched target's
// response is passed back to the CPU. Unmapped or illegal accesses get a
// one-cycle error response. A stalled target is cut off after TIMEOUT cycles.

package bus_router_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;
endpackage

module bus_router
  import bus_router_pkg::*;
#(
  parameter logic [31:0] RAM_SIZE = 32'h00010000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  cpu_in,
  output mem_out_type cpu_out,
  output mem_in_type  rom_in,
  output mem_in_type  ram_in,
  output mem_in_type  uart_in,
  output mem_in_type  clint_in,
  input  mem_out_type rom_out,
  input  mem_out_type ram_out,
  input  mem_out_type uart_out,
  input  mem_out_type clint_out
);

  typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;
  typedef enum logic [1:0] {SEL_ROM, SEL_RAM, SEL_UART, SEL_CLINT} sel_t;

  localparam logic [31:0] RAM_BASE = 32'h80000000;
  localparam logic [31:0] RAM_MASK = ~(RAM_SIZE - 32'd1);
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  sel_t        r_sel, w_dec_sel;
  logic [7:0]  r_cnt;

  logic        w_hit_rom, w_hit_ram, w_hit_uart, w_hit_clint;
  logic        w_mapped, w_legal;
  logic        w_take, w_fwd, w_cnt_inc;
  mem_out_type w_sel_out;

  // Address decode of the incoming CPU request
  always_comb begin
    w_hit_rom   = (cpu_in.mem_addr[31:8] == 24'h000000);
    w_hit_uart  = (cpu_in.mem_addr[31:4] == 28'h0100000);
    w_hit_clint = (cpu_in.mem_addr[31:16] == 16'h0200);
    w_hit_ram   = ((cpu_in.mem_addr & RAM_MASK) == RAM_BASE);
    w_mapped    = w_hit_rom | w_hit_uart | w_hit_clint | w_hit_ram;
    // ROM is read-only: any byte strobe makes the access illegal
    w_legal     = w_mapped & ~(w_hit_rom & (|cpu_in.mem_wstrb));
    w_dec_sel   = SEL_ROM;
    if (w_hit_ram)        w_dec_sel = SEL_RAM;
    else if (w_hit_uart)  w_dec_sel = SEL_UART;
    else if (w_hit_clint) w_dec_sel = SEL_CLINT;
  end

  // Response mux from the latched target
  always_comb begin
    w_sel_out = rom_out;
    case (r_sel)
      SEL_RAM:   w_sel_out = ram_out;
      SEL_UART:  w_sel_out = uart_out;
      SEL_CLINT: w_sel_out = clint_out;
      default:   w_sel_out = rom_out;
    endcase
  end

  // Next-state, CPU response and forward decision
  always_comb begin
    w_next    = r_state;
    cpu_out   = '0;
    w_take    = 1'b0;
    w_fwd     = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      IDLE: w_take = 1'b1;
      BUSY: begin
        if (w_sel_out.mem_ready) begin
          cpu_out = w_sel_out;
          w_next  = IDLE;
          // Completion cycle doubles as an acceptance cycle (zero bubble)
          w_take  = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          cpu_out.mem_ready = 1'b1;
          cpu_out.mem_error = 1'b1;
          w_next            = IDLE;
        end else begin
          cpu_out   = w_sel_out;
          w_cnt_inc = 1'b1;
        end
      end
      ERROR: begin
        cpu_out.mem_ready = 1'b1;
        cpu_out.mem_error = 1'b1;
        w_next            = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Gate with reset so nothing is forwarded while reset is held low
    if (w_take && cpu_in.mem_valid && reset) begin
      if (w_legal) begin
        w_fwd  = 1'b1;
        w_next = BUSY;
      end else begin
        w_next = ERROR;
      end
    end
  end

  // Broadcast request fields; valid only to the decoded target on acceptance
  always_comb begin
    rom_in             = cpu_in;
    ram_in             = cpu_in;
    uart_in            = cpu_in;
    clint_in           = cpu_in;
    rom_in.mem_valid   = w_fwd & (w_dec_sel == SEL_ROM);
    ram_in.mem_valid   = w_fwd & (w_dec_sel == SEL_RAM);
    uart_in.mem_valid  = w_fwd & (w_dec_sel == SEL_UART);
    clint_in.mem_valid = w_fwd & (w_dec_sel == SEL_CLINT);
  end

  // State, target select and timeout counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sel   <= SEL_ROM;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_fwd) begin
        r_sel <= w_dec_sel;
        r_cnt <= 8'd0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/bus_router.md
BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32'h00010000, RAM region size in bytes (power of two).
REQ-002 SHALL have parameter TIMEOUT, default 255, cycles a forwarded request may wait for a target response (2..255).
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port cpu_in  input  mem_in_type  CPU request (mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb).
REQ-006 SHALL have port cpu_out  output  mem_out_type  CPU response (mem_ready, mem_error, mem_rdata).
REQ-007 SHALL have ports rom_in/ram_in/uart_in/clint_in  output  mem_in_type  requests to each target.
REQ-008 SHALL have ports rom_out/ram_out/uart_out/clint_out  input  mem_out_type  responses from each target.

Function
REQ-009 SHALL decode cpu_in.mem_addr: ROM 0x00000000-0x000000FF; UART 0x01000000-0x0100000F; CLINT 0x02000000-0x0200FFFF; RAM 0x80000000 to 0x80000000+RAM_SIZE-1; everything else unmapped.
REQ-010 SHALL broadcast mem_addr, mem_wdata, mem_wstrb, mem_instr unchanged to all four target ports.
REQ-011 SHALL drive target mem_valid combinationally, high for exactly the acceptance cycle and only on the decoded target.
REQ-012 SHALL use FSM states IDLE, BUSY, ERROR; reset state IDLE.
REQ-013 IDLE: cpu_in.mem_valid=1 with mapped, legal address -> forward, latch target select, clear timeout counter, go BUSY.
REQ-014 IDLE: mem_valid=1 with unmapped address, or mem_wstrb!=0 to ROM -> no forward, go ERROR.
REQ-015 ERROR: cpu_out.mem_ready=1, mem_error=1, mem_rdata=0 for one cycle, then IDLE (error latency 1 cycle).
REQ-016 BUSY: cpu_out SHALL combinationally mirror the latched target's mem_ready, mem_error, mem_rdata; non-selected target responses ignored.
REQ-017 BUSY with selected mem_ready=1 -> response completes this cycle; next state IDLE.
REQ-018 Simultaneous event: cpu_in.mem_valid=1 in the same cycle the BUSY response completes SHALL be accepted per REQ-013/014 in that cycle (back-to-back, zero bubble).
REQ-019 BUSY: cpu_in.mem_valid in any cycle without completing response SHALL be ignored (CPU holds one outstanding request).
REQ-020 BUSY: 8-bit counter increments each cycle without ready; on reaching TIMEOUT-1 without ready, cpu_out SHALL give mem_ready=1, mem_error=1, mem_rdata=0 that cycle and go IDLE.
REQ-021 A target mem_ready arriving after timeout or while IDLE SHALL be discarded, never reaching cpu_out.
REQ-022 Outside REQ-015/016/020, cpu_out SHALL be mem_ready=0, mem_error=0, mem_rdata=0.
REQ-023 Minimum read latency through ROM SHALL be 1 cycle (valid at edge N, ready/data at cycle N+1).

Reset
REQ-024 Reset low SHALL immediately force state IDLE, counter 0, target select ROM, all target mem_valid=0, cpu_out all zero.
REQ-025 Reset asserted mid-BUSY SHALL abandon the transaction; no response produced after reset release.
REQ-026 First request SHALL be accepted on the first rising edge with reset high.

Verification
REQ-027 ROM read addr 0x00000004 -> rom_in.mem_valid=1 one cycle only, next cycle cpu_out.mem_ready=1, mem_error=0, rdata=rom rdata.
REQ-028 Read 0x40000000 (unmapped) -> no target valid; next cycle mem_ready=1, mem_error=1, rdata=0; then idle.
REQ-029 Write wstrb=4'hF to 0x00000010 -> ROM not selected; error response next cycle.
REQ-030 RAM read at 0x80000000 with stub never asserting ready, TIMEOUT=8 -> error response exactly 8 cycles after acceptance; later stub ready ignored.
REQ-031 Back-to-back: ROM read completes while new UART read 0x01000004 valid same cycle -> uart_in.mem_valid=1 that cycle, UART response delivered with no idle cycle.
REQ-032 Reset pulsed low during BUSY on RAM read with delayed ready -> all outputs zero immediately; stale ready after release produces no cpu_out.mem_ready.
